// File: rtl/cache_types_pkg.sv
// Shared widths and the adaptor state encoding for the cache-to-memory
// line adaptor.
package cache_types_pkg;

  localparam int LINE_W  = 256;
  localparam int BURST_W = 64;
  localparam int BEATS   = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } adaptor_state_e;

endpackage

// File: rtl/cacheline_adaptor.sv
// Splits cache line write-backs into four memory beats and assembles four
// memory read beats into a cache line, with one-cycle completion pulse.
module cacheline_adaptor #(
  parameter int LINE_W  = cache_types_pkg::LINE_W,
  parameter int BURST_W = cache_types_pkg::BURST_W  // LINE_W must be 4*BURST_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);
  import cache_types_pkg::*;

  localparam int OFFSET_W = $clog2(LINE_W / 8);

  adaptor_state_e    state;
  logic [1:0]        cnt;
  logic [1:0]        cnt_next;
  logic              last_beat;
  logic [LINE_W-1:0] line_q;
  logic [LINE_W-1:0] line_buf;
  logic [31:0]       addr_aligned;
  logic              unused_addr_bits;

  assign cnt_next         = cnt + 2'd1;
  assign last_beat        = (cnt == 2'(BEATS - 1));
  assign addr_aligned     = {address_i[31:OFFSET_W], OFFSET_W'(0)};
  assign unused_addr_bits = ^address_i[OFFSET_W-1:0];
  assign line_o           = line_buf;

  // All outputs are registered: they change on the edge that enters or
  // leaves a state, so they track the state with no combinational decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the line buffers are plain flops, not RAM, so clearing them in
      // reset is cheap and keeps line_o defined from power-up.
      state     <= ST_IDLE;
      cnt       <= '0;
      line_q    <= '0;
      line_buf  <= '0;
      resp_o    <= 1'b0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      address_o <= '0;
      burst_o   <= '0;
    end else begin
      // NOTE: non-blocking assignments everywhere here, so every branch reads
      // the pre-edge value of cnt/state regardless of statement order.
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (read_i) begin
            state     <= ST_READ;
            read_o    <= 1'b1;
            address_o <= addr_aligned;
          end else if (write_i) begin
            state     <= ST_WRITE;
            write_o   <= 1'b1;
            address_o <= addr_aligned;
            line_q    <= line_i;
            burst_o   <= line_i[BURST_W-1:0];
          end
        end

        ST_READ: begin
          if (resp_i) begin
            line_buf[int'(cnt)*BURST_W +: BURST_W] <= burst_i;
            if (last_beat) begin
              state     <= ST_DONE;
              cnt       <= '0;
              read_o    <= 1'b0;
              address_o <= '0;
              resp_o    <= 1'b1;
            end else begin
              cnt <= cnt_next;
            end
          end
        end

        ST_WRITE: begin
          if (resp_i) begin
            if (last_beat) begin
              state     <= ST_DONE;
              cnt       <= '0;
              write_o   <= 1'b0;
              address_o <= '0;
              burst_o   <= '0;
              resp_o    <= 1'b1;
            end else begin
              cnt     <= cnt_next;
              burst_o <= line_q[int'(cnt_next)*BURST_W +: BURST_W];
            end
          end
        end

        ST_DONE: begin
          state  <= ST_IDLE;
          resp_o <= 1'b0;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: expected lines and write beats are
// queued when stimulus is driven and popped when the DUT presents them.
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int tests_run = 0;
  int tests_failed = 0;

  logic [255:0] line_q[$];
  logic [63:0]  beat_q[$];
  logic [255:0] last_line;

  cacheline_adaptor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a read; pat[i] is resp_i for the i-th READ cycle and must hold
  // exactly four ones, the last of them at index pat_len-1.
  task automatic run_read(input logic [31:0] addr, input logic [255:0] exp_line,
                          input logic [15:0] pat, input int pat_len, input logic also_write);
    int b;
    line_q.push_back(exp_line);
    read_i    = 1'b1;
    write_i   = also_write;
    address_i = addr;
    step();
    check("rd_read_o", read_o, 1'b1);
    check("rd_address_o", address_o, {addr[31:5], 5'b0});
    b = 0;
    for (int i = 0; i < pat_len; i++) begin
      check("rd_no_write_o", write_o, 1'b0);
      check("rd_no_early_resp", resp_o, 1'b0);
      resp_i  = pat[i];
      burst_i = pat[i] ? exp_line[64*b +: 64] : 64'hBAD0_BAD0_BAD0_BAD0;
      if (pat[i]) b++;
      step();
    end
    resp_i  = 1'b0;
    burst_i = '0;
    check("rd_resp_o", resp_o, 1'b1);
    check("rd_read_o_done", read_o, 1'b0);
    check("rd_address_o_done", address_o, 32'h0);
    last_line = line_q.pop_front();
    check("rd_line_o", line_o, last_line);
    read_i  = 1'b0;
    write_i = 1'b0;
    step();
    check("rd_resp_o_single", resp_o, 1'b0);
    check("rd_line_o_hold", line_o, last_line);
  endtask

  // Issue a write; pat[i] is resp_i for the i-th WRITE cycle (four ones).
  task automatic run_write(input logic [31:0] addr, input logic [255:0] line,
                           input logic [15:0] pat, input int pat_len);
    for (int k = 0; k < 4; k++) beat_q.push_back(line[64*k +: 64]);
    write_i   = 1'b1;
    line_i    = line;
    address_i = addr;
    step();
    line_i    = ~line;
    address_i = 32'hFFFF_FFFF;
    check("wr_address_o", address_o, {addr[31:5], 5'b0});
    for (int i = 0; i < pat_len; i++) begin
      check("wr_write_o", write_o, 1'b1);
      check("wr_no_read_o", read_o, 1'b0);
      check("wr_burst_o", burst_o, beat_q[0]);
      resp_i = pat[i];
      if (pat[i]) void'(beat_q.pop_front());
      step();
    end
    resp_i = 1'b0;
    check("wr_resp_o", resp_o, 1'b1);
    check("wr_write_o_done", write_o, 1'b0);
    check("wr_burst_o_done", burst_o, 64'h0);
    check("wr_line_o_untouched", line_o, last_line);
    write_i = 1'b0;
    step();
    check("wr_resp_o_single", resp_o, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b0;
    line_i    = '0;
    address_i = '0;
    read_i    = 1'b0;
    write_i   = 1'b0;
    burst_i   = '0;
    resp_i    = 1'b0;
    last_line = '0;
    step();
    step();
    check("rst_resp_o", resp_o, 1'b0);
    check("rst_read_o", read_o, 1'b0);
    check("rst_write_o", write_o, 1'b0);
    check("rst_address_o", address_o, 32'h0);
    check("rst_burst_o", burst_o, 64'h0);
    check("rst_line_o", line_o, 256'h0);
    rst_n = 1'b1;
    step();

    // Back-to-back read at minimum latency.
    run_read(32'h1234_5678,
             {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
              64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
             16'b1111, 4, 1'b0);

    // Write, then a write with stalls between beats.
    run_write(32'hABCD_EF1F,
              {64'hD3D3_D3D3_0000_0003, 64'hD2D2_D2D2_0000_0002,
               64'hD1D1_D1D1_0000_0001, 64'hD0D0_D0D0_0000_0000},
              16'b1111, 4);
    run_write(32'h0000_0040,
              {64'hCAFE_0000_0000_0003, 64'hCAFE_0000_0000_0002,
               64'hCAFE_0000_0000_0001, 64'hCAFE_0000_0000_0000},
              16'b1001_0011, 8);

    // Stalled read: resp_i pattern 1,0,0,1,1,0,1 (LSB first).
    run_read(32'h8000_0020,
             {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2,
              64'hA1A1_A1A1_A1A1_A1A1, 64'hA0A0_A0A0_A0A0_A0A0},
             16'b1011001, 7, 1'b0);

    // read_i and write_i together: read wins, write_o never rises.
    run_read(32'h0000_1000,
             {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
              64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_0F0F_F0F0},
             16'b1111, 4, 1'b1);

    // resp_i pulses in IDLE are ignored.
    for (int i = 0; i < 3; i++) begin
      resp_i  = 1'b1;
      burst_i = 64'hEEEE_EEEE_EEEE_EEEE;
      step();
      check("idle_line_o_unchanged", line_o, last_line);
      check("idle_no_read_o", read_o, 1'b0);
      check("idle_no_resp_o", resp_o, 1'b0);
    end
    resp_i  = 1'b0;
    burst_i = '0;

    // Reset mid-read after two beats: outputs clear without waiting for a clock.
    read_i    = 1'b1;
    address_i = 32'h7777_7777;
    step();
    resp_i = 1'b1;
    burst_i = 64'h9999_9999_9999_9999;
    step();
    step();
    resp_i  = 1'b0;
    read_i  = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_read_o", read_o, 1'b0);
    check("mid_rst_address_o", address_o, 32'h0);
    check("mid_rst_line_o", line_o, 256'h0);
    check("mid_rst_resp_o", resp_o, 1'b0);
    step();
    rst_n = 1'b1;
    last_line = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_no_resp_o", resp_o, 1'b0);
      check("post_rst_idle_read_o", read_o, 1'b0);
    end

    // A fresh read after reset assembles cleanly.
    run_read(32'h1234_5678,
             {64'h8888_7777_6666_5555, 64'h4444_3333_2222_1111,
              64'hDEAD_BEEF_DEAD_BEEF, 64'h0BAD_F00D_0BAD_F00D},
             16'b1111, 4, 1'b0);

    check("scoreboard_lines_drained", 32'(line_q.size()), 32'd0);
    check("scoreboard_beats_drained", 32'(beat_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
